// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instruction memory, holds a
//   fetched word while IF/ID stalls, and redirects on resolved branches/jumps.
// Latency: zero added; the fetched word passes combinationally to IF/ID on ihit.
// Backpressure: stall parks the fetched word in a hold buffer and drops iren
//   until IF/ID accepts it.
//
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   iren/iaddr          instruction-memory request; iaddr is the PC register
//   ihit/iload          memory response and its data
//   stall               IF/ID cannot accept this cycle
//   redirect/redirect_pc taken branch/jump target from downstream
//   halt                stop fetching until RST
//   out_valid/out_instr/out_pc/out_npc  payload for IF/ID
//   halted              fetch stopped by halt
//   misalign            sticky misaligned-redirect flag (FETCH_MISALIGN_EN only)
//
// Build option: define FETCH_MISALIGN_EN to force redirect targets to word
// alignment and report misaligned targets on misalign.

module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          PC_W    = 32,
    parameter int          INSTR_W = 32
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               iren,
    output logic [PC_W-1:0]    iaddr,
    input  logic               ihit,
    input  logic [INSTR_W-1:0] iload,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_npc,
    output logic               halted
`ifdef FETCH_MISALIGN_EN
    ,
    output logic               misalign
`endif
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     pc, pc_nxt;
    logic [INSTR_W-1:0]  hold_buf, hold_nxt;
    logic [PC_W-1:0]     pc_plus4;
    logic [PC_W-1:0]     redirect_tgt;

    assign pc_plus4 = pc + PC_W'(4);

`ifdef FETCH_MISALIGN_EN
    logic misalign_set;

    assign redirect_tgt = {redirect_pc[PC_W-1:2], 2'b00};
    // Only a redirect that actually takes effect can flag misalignment:
    // halt outranks redirect, and a halted stage ignores redirects.
    assign misalign_set = redirect && !halt && (state != HALTED)
                        && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge CLK) begin
        if (RST) begin
            misalign <= 1'b0;
        end else if (misalign_set) begin
            misalign <= 1'b1;
        end
    end
`else
    assign redirect_tgt = redirect_pc;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= FETCH;
            pc       <= PC_W'(PC_INIT);
            hold_buf <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            hold_buf <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        hold_nxt  = hold_buf;
        iren      = 1'b0;
        out_valid = 1'b0;
        out_instr = '0;

        // Normal operation first; redirect, halt and reset then override in
        // increasing priority order.
        case (state)
            FETCH: begin
                iren = 1'b1;
                if (ihit) begin
                    out_valid = 1'b1;
                    out_instr = iload;
                    if (stall) begin
                        hold_nxt  = iload;
                        state_nxt = HOLD;
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                out_instr = hold_buf;
                if (!stall) begin
                    pc_nxt    = pc_plus4;
                    state_nxt = FETCH;
                end
            end
            default: begin
                // HALTED: nothing issued, nothing emitted.
            end
        endcase

        // Any in-flight ihit or held word is wrong-path after a redirect.
        if (redirect && (state != HALTED)) begin
            pc_nxt    = redirect_tgt;
            state_nxt = FETCH;
            hold_nxt  = '0;
            out_valid = 1'b0;
            out_instr = '0;
        end

        if (halt) begin
            pc_nxt    = pc;
            hold_nxt  = hold_buf;
            state_nxt = HALTED;
            out_valid = 1'b0;
            out_instr = '0;
        end

        if (RST) begin
            iren      = 1'b0;
            out_valid = 1'b0;
            out_instr = '0;
        end
    end

    assign iaddr   = pc;
    assign out_pc  = pc;
    assign out_npc = pc_plus4;
    assign halted  = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage: each row drives one cycle of
// inputs and lists the outputs expected before the next rising edge.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iren;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic        halted;
`ifdef FETCH_MISALIGN_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(
        .PC_INIT(32'h0000_0000),
        .PC_W(32),
        .INSTR_W(32)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .iren(iren),
        .iaddr(iaddr),
        .ihit(ihit),
        .iload(iload),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_npc(out_npc),
        .halted(halted)
`ifdef FETCH_MISALIGN_EN
        ,
        .misalign(misalign)
`endif
    );

    typedef struct {
        logic        rst;
        logic        ihit;
        logic [31:0] iload;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic        e_iren;
        logic [31:0] e_pc;
        logic        e_ov;
        logic [31:0] e_oi;
        logic        e_halted;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic ih, input logic [31:0] ld,
                               input logic st, input logic rd, input logic [31:0] rp,
                               input logic hl, input logic e_iren, input logic [31:0] e_pc,
                               input logic e_ov, input logic [31:0] e_oi, input logic e_hl);
        vec_t r;
        r.rst = rst; r.ihit = ih; r.iload = ld; r.stall = st; r.redir = rd;
        r.rpc = rp; r.halt = hl; r.e_iren = e_iren; r.e_pc = e_pc; r.e_ov = e_ov;
        r.e_oi = e_oi; r.e_halted = e_hl;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then compare before the rising edge.
    task automatic apply(input vec_t r, input int row);
        @(negedge CLK);
        RST = r.rst; ihit = r.ihit; iload = r.iload; stall = r.stall;
        redirect = r.redir; redirect_pc = r.rpc; halt = r.halt;
        #1;
        chk("iren", row, {31'd0, iren}, {31'd0, r.e_iren});
        chk("iaddr", row, iaddr, r.e_pc);
        chk("out_valid", row, {31'd0, out_valid}, {31'd0, r.e_ov});
        chk("out_instr", row, out_instr, r.e_oi);
        chk("out_pc", row, out_pc, r.e_pc);
        chk("out_npc", row, out_npc, r.e_pc + 32'd4);
        chk("halted", row, {31'd0, halted}, {31'd0, r.e_halted});
    endtask

`ifdef FETCH_MISALIGN_EN
    task automatic chk_mis(input int row, input logic exp);
        chk("misalign", row, {31'd0, misalign}, {31'd0, exp});
    endtask
`endif

    vec_t tbl[24];

    initial begin
        RST = 1'b1; ihit = 1'b0; iload = '0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

        //          rst ih iload         st rd rpc            hl  iren pc            ov oi            halted
        tbl[0]  = v(1, 1, 32'h0000_00EE, 0, 0, 32'h0,         0,  0,   32'h0,        0, 32'h0,        0);
        tbl[1]  = v(0, 1, 32'h0000_0011, 0, 0, 32'h0,         0,  1,   32'h0,        1, 32'h11,       0);
        tbl[2]  = v(0, 1, 32'h0000_0022, 0, 0, 32'h0,         0,  1,   32'h4,        1, 32'h22,       0);
        tbl[3]  = v(0, 1, 32'h0000_0033, 0, 0, 32'h0,         0,  1,   32'h8,        1, 32'h33,       0);
        tbl[4]  = v(0, 1, 32'h0000_0099, 0, 1, 32'h10,        0,  1,   32'hC,        0, 32'h0,        0);
        tbl[5]  = v(0, 1, 32'h0000_ABCD, 1, 0, 32'h0,         0,  1,   32'h10,       1, 32'hABCD,     0);
        tbl[6]  = v(0, 0, 32'h0000_0000, 1, 0, 32'h0,         0,  0,   32'h10,       1, 32'hABCD,     0);
        tbl[7]  = v(0, 1, 32'h0000_1234, 1, 0, 32'h0,         0,  0,   32'h10,       1, 32'hABCD,     0);
        tbl[8]  = v(0, 0, 32'h0000_0000, 0, 0, 32'h0,         0,  0,   32'h10,       1, 32'hABCD,     0);
        tbl[9]  = v(0, 0, 32'h0000_0000, 0, 1, 32'h20,        0,  1,   32'h14,       0, 32'h0,        0);
        tbl[10] = v(0, 0, 32'h0000_DEAD, 0, 0, 32'h0,         0,  1,   32'h20,       0, 32'h0,        0);
        tbl[11] = v(0, 0, 32'h0000_DEAD, 1, 0, 32'h0,         0,  1,   32'h20,       0, 32'h0,        0);
        tbl[12] = v(0, 0, 32'h0000_DEAD, 0, 0, 32'h0,         0,  1,   32'h20,       0, 32'h0,        0);
        tbl[13] = v(0, 0, 32'h0000_DEAD, 0, 0, 32'h0,         0,  1,   32'h20,       0, 32'h0,        0);
        tbl[14] = v(0, 1, 32'h0000_0055, 0, 0, 32'h0,         0,  1,   32'h20,       1, 32'h55,       0);
        tbl[15] = v(0, 1, 32'h0000_0066, 1, 0, 32'h0,         0,  1,   32'h24,       1, 32'h66,       0);
        tbl[16] = v(0, 0, 32'h0000_0000, 1, 1, 32'h400,       0,  0,   32'h24,       0, 32'h0,        0);
        tbl[17] = v(0, 0, 32'h0000_0000, 0, 0, 32'h0,         0,  1,   32'h400,      0, 32'h0,        0);
        tbl[18] = v(0, 1, 32'h0000_0077, 0, 0, 32'h0,         0,  1,   32'h400,      1, 32'h77,       0);
        tbl[19] = v(0, 1, 32'h0000_0123, 0, 1, 32'hFFFF_FFFC, 0,  1,   32'h404,      0, 32'h0,        0);
        tbl[20] = v(0, 1, 32'h0000_0088, 0, 0, 32'h0,         0,  1,   32'hFFFF_FFFC,1, 32'h88,       0);
        tbl[21] = v(0, 0, 32'h0000_0000, 0, 0, 32'h0,         0,  1,   32'h0,        0, 32'h0,        0);
        tbl[22] = v(0, 0, 32'h0000_0000, 0, 1, 32'h40,        0,  1,   32'h0,        0, 32'h0,        0);
        // halt and redirect together: halt wins, pc stays 0x40
        tbl[23] = v(0, 1, 32'h0000_0099, 0, 1, 32'h80,        1,  1,   32'h40,       0, 32'h0,        0);

        repeat (2) @(posedge CLK);

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i], i);
        end

        // Halted for 10 cycles: redirects and hits must not move the PC.
        for (int i = 0; i < 10; i++) begin
            apply(v(0, 1, 32'h5A5A_0000 + i, i[0], ~i[0], 32'h800, 0,
                    0, 32'h40, 0, 32'h0, 1), 100 + i);
        end

        // Reset leaves HALTED and restores PC_INIT.
        apply(v(1, 1, 32'h1, 0, 0, 32'h0, 0, 0, 32'h40, 0, 32'h0, 1), 200);
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h0,  0, 32'h0, 0), 201);

        // Misaligned redirect target.
        apply(v(0, 0, 32'h0, 0, 1, 32'h102, 0, 1, 32'h0, 0, 32'h0, 0), 300);
`ifdef FETCH_MISALIGN_EN
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h100, 0, 32'h0, 0), 301);
        chk_mis(301, 1'b1);
        for (int i = 0; i < 5; i++) begin
            apply(v(0, 0, 32'h0, 0, 1, 32'h200 + 32'(i * 16), 0, 1,
                    (i == 0) ? 32'h100 : 32'h200 + 32'((i - 1) * 16), 0, 32'h0, 0), 310 + i);
            chk_mis(310 + i, 1'b1);
        end
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h240, 0, 32'h0, 0), 320);
        chk_mis(320, 1'b1);
        apply(v(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h240, 0, 32'h0, 0), 321);
        apply(v(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0), 322);
        chk_mis(322, 1'b0);
`else
        apply(v(0, 1, 32'h3C, 0, 0, 32'h0, 0, 1, 32'h102, 1, 32'h3C, 0), 301);
        apply(v(0, 0, 32'h0,  0, 0, 32'h0, 0, 1, 32'h106, 0, 32'h0,  0), 302);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC, issues instruction-memory requests, and waits on ihit.
- Holds a fetched instruction when IF/ID is stalled, and redirects on branch/jump resolution.
- Produces the instr/pc/npc bundle that IF/ID latches into its instruction-fetch payload.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC and address width.
- INSTR_W, 32, instruction word width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- iren  out  1  instruction-memory read request.
- iaddr  out  PC_W  instruction address; equals the PC register.
- ihit  in  1  instruction memory returned iload this cycle.
- iload  in  INSTR_W  instruction data, valid when ihit=1.
- stall  in  1  IF/ID cannot accept; OR of the ifid and all-stall terms from the hazard unit.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  PC_W  target PC for redirect.
- halt  in  1  halt instruction decoded; stop fetching.
- out_valid  out  1  out_instr/out_pc/out_npc are a real instruction.
- out_instr  out  INSTR_W  instruction to IF/ID; 0 when out_valid=0.
- out_pc  out  PC_W  PC of out_instr.
- out_npc  out  PC_W  out_pc + 4, modulo 2^PC_W.
- halted  out  1  fetch stopped by halt.

Behaviour:
- Reset (RST=1 at a rising edge):
  - pc=PC_INIT, state=FETCH, hold buffer=0, halted=0.
  - While RST is high, iren=0 and out_valid=0.
- States: FETCH, HOLD, HALTED.
- FETCH:
  - Drives iren=1 and iaddr=pc.
  - out_valid=ihit, out_instr=iload (0 if !ihit), out_pc=pc, out_npc=pc+4 (combinational pass-through, zero added latency).
  - ihit=1 and stall=0: next pc=pc+4; stay in FETCH.
  - ihit=1 and stall=1: capture iload into the hold buffer; pc unchanged; go to HOLD.
  - ihit=0: pc unchanged; stay in FETCH, so iren remains asserted across miss cycles.
- HOLD:
  - iren=0, out_valid=1, out_instr=hold buffer, out_pc=pc, out_npc=pc+4.
  - stall=0: next pc=pc+4; go to FETCH.
  - stall=1: remain in HOLD; the buffer is unchanged.
- HALTED:
  - iren=0, out_valid=0, halted=1. Only RST exits this state.
- Priority each cycle, highest first: RST, halt, redirect, normal operation.
- halt=1 (any state other than reset): go to HALTED next cycle; out_valid=0 in the halt cycle; pc frozen.
- redirect=1 (not halted):
  - next pc=redirect_pc; state=FETCH; hold buffer discarded.
  - out_valid=0 in the redirect cycle, regardless of ihit or stall.
  - The in-flight ihit is ignored.
- Redirect while stall=1: redirect still applies. The squashed wrong-path instruction is the responsibility of downstream flush.
- Simultaneous halt and redirect: halt wins; pc stays at its current value.
- pc+4 wraps modulo 2^PC_W: 32'hFFFF_FFFC yields 32'h0000_0000.
- The PC register, state, hold buffer, and halted are all flops. Outputs are combinational from state and inputs only as stated above.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined:
  - Adds output port misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets misalign sticky until RST.
  - The loaded pc is forced to {redirect_pc[PC_W-1:2],2'b00}.
- Undefined:
  - No misalign port.
  - redirect_pc is loaded unmodified.
  - Low PC bits pass to iaddr as-is.

Test Plan:
- Reset, then ihit=1 every cycle with iload=0x11,0x22,0x33 and stall=0 -> iaddr=0,4,8; out_valid=1; out_instr=0x11,0x22,0x33; out_npc=4,8,12.
- pc=0x10, ihit=1, iload=0xABCD, stall=1 for 3 cycles -> state HOLD; iren=0; out_instr=0xABCD and out_pc=0x10 held for all 3 cycles; pc=0x14 after stall drops; iren=1.
- ihit=0 for 4 cycles at pc=0x20 -> iren=1, iaddr=0x20, out_valid=0 throughout; pc advances only on the ihit cycle.
- In HOLD, redirect=1 with redirect_pc=0x400 -> out_valid=0 that cycle; next iaddr=0x400; state FETCH; the old buffer is never emitted.
- halt=1 and redirect=1 together at pc=0x40 -> halted=1; iren=0; pc stays 0x40 for 10 cycles; RST restores pc=PC_INIT and halted=0.
- FETCH_MISALIGN_EN defined: redirect_pc=0x102 -> iaddr=0x100, misalign=1, still 1 after 5 further redirects to aligned targets; clears on RST. pc=0xFFFFFFFC with ihit=1 -> next iaddr=0.
